// File: rtl/ceespu_pkg.sv
// ceespu_pkg: shared constants and types for the CEESPU memory arbiter.
//   arb_state_e    : owner of the in-flight memory access (IDLE/FETCH/DATA)
//   ARB_FAIR_LIMIT : consecutive data wins over a pending fetch before fetch is forced
package ceespu_pkg;

  localparam int unsigned MEM_AW         = 14;
  localparam int unsigned MEM_DW         = 32;
  localparam int unsigned MEM_BE         = 4;
  localparam int unsigned FAIR_CNT_W     = 3;
  localparam int unsigned ARB_FAIR_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_e;

endpackage : ceespu_pkg

// File: rtl/ceespu_mem_arbiter.sv
// ceespu_mem_arbiter: shares one synchronous single-port memory between the
// instruction fetch and the execute-stage load/store port.
//   I_clk, I_rst                 : clock, synchronous active-high reset
//   I_fetch*                     : fetch word-read request
//   I_data*                      : load/store request (I_dataWe==0 means load)
//   I_memRdata                   : memory read data, one cycle after the access
//   O_mem*                       : memory port, driven in the grant cycle
//   O_fetchData/O_fetchValid     : fetch response (held between responses)
//   O_dataRdata/O_dataValid      : data response (held between load responses)
//   O_stallFetch/O_stallData     : request not granted this cycle
// Optional feature: define CEESPU_ARB_FAIRNESS_EN to stop data from starving
// fetch indefinitely; otherwise data has strict priority.
module ceespu_mem_arbiter
  import ceespu_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_fetchReq,
  input  logic [13:0] I_fetchAddr,
  input  logic        I_dataReq,
  input  logic [3:0]  I_dataWe,
  input  logic [31:0] I_dataAddr,
  input  logic [31:0] I_dataWdata,
  input  logic [31:0] I_memRdata,
  output logic        O_memE,
  output logic [3:0]  O_memWe,
  output logic [13:0] O_memAddr,
  output logic [31:0] O_memWdata,
  output logic [31:0] O_fetchData,
  output logic        O_fetchValid,
  output logic [31:0] O_dataRdata,
  output logic        O_dataValid,
  output logic        O_stallFetch,
  output logic        O_stallData
);

  arb_state_e  state_q, state_d;
  logic        rd_q, rd_d;          // in-flight data access is a load
  logic        fetch_grant, data_grant;
  logic        fetch_turn;
  logic [31:0] fetch_data_q, data_rdata_q;

  // Byte-offset and upper address bits are outside the 64 KiB memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{I_dataAddr[31:16], I_dataAddr[1:0]};

`ifdef CEESPU_ARB_FAIRNESS_EN
  logic [FAIR_CNT_W-1:0] fair_cnt_q, fair_cnt_d;

  assign fetch_turn = (fair_cnt_q == FAIR_CNT_W'(ARB_FAIR_LIMIT));

  // Count data wins while fetch waits; any fetch win or idle fetch clears it.
  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (!I_fetchReq || fetch_grant) begin
      fair_cnt_d = '0;
    end else if (data_grant) begin
      fair_cnt_d = fair_cnt_q + FAIR_CNT_W'(1);
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      fair_cnt_q <= '0;
    end else begin
      fair_cnt_q <= fair_cnt_d;
    end
  end
`else
  assign fetch_turn = 1'b0;
`endif

  // Grant: data wins unless fetch has waited its turn out.
  assign data_grant  = I_dataReq & ~(I_fetchReq & fetch_turn);
  assign fetch_grant = I_fetchReq & ~data_grant;

  // State register.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
    end
  end

  // Next state: the owner granted this cycle.
  always_comb begin
    state_d = ST_IDLE;
    rd_d    = 1'b0;
    if (data_grant) begin
      state_d = ST_DATA;
      rd_d    = (I_dataWe == 4'b0000);
    end else if (fetch_grant) begin
      state_d = ST_FETCH;
    end
  end

  // Outputs: memory port from the grant, responses from the registered owner.
  // A response still in flight when reset asserts is suppressed.
  always_comb begin
    O_memE       = fetch_grant | data_grant;
    O_memAddr    = data_grant ? I_dataAddr[15:2] : I_fetchAddr;
    O_memWe      = data_grant ? I_dataWe : 4'b0000;
    O_memWdata   = I_dataWdata;
    O_stallFetch = I_fetchReq & ~fetch_grant;
    O_stallData  = I_dataReq & ~data_grant;
    O_fetchValid = (state_q == ST_FETCH) & ~I_rst;
    O_dataValid  = (state_q == ST_DATA) & ~I_rst;
    O_fetchData  = O_fetchValid ? I_memRdata : fetch_data_q;
    O_dataRdata  = (O_dataValid & rd_q) ? I_memRdata : data_rdata_q;
  end

  // Held response words.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      fetch_data_q <= '0;
      data_rdata_q <= '0;
    end else begin
      if (O_fetchValid) begin
        fetch_data_q <= I_memRdata;
      end
      if (O_dataValid && rd_q) begin
        data_rdata_q <= I_memRdata;
      end
    end
  end

endmodule : ceespu_mem_arbiter

// File: tb/tb_ceespu_mem_arbiter.sv
// Testbench for ceespu_mem_arbiter: a behavioural synchronous memory, a
// directed stimulus thread that checks grant-cycle outputs and queues the
// expected responses, and a monitor that pops and checks each response.
module tb_ceespu_mem_arbiter;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_fetchReq = 1'b0;
  logic [13:0] I_fetchAddr = '0;
  logic        I_dataReq = 1'b0;
  logic [3:0]  I_dataWe = '0;
  logic [31:0] I_dataAddr = '0;
  logic [31:0] I_dataWdata = '0;
  logic [31:0] I_memRdata;
  logic        O_memE;
  logic [3:0]  O_memWe;
  logic [13:0] O_memAddr;
  logic [31:0] O_memWdata;
  logic [31:0] O_fetchData;
  logic        O_fetchValid;
  logic [31:0] O_dataRdata;
  logic        O_dataValid;
  logic        O_stallFetch;
  logic        O_stallData;

  ceespu_mem_arbiter dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_fetchReq(I_fetchReq), .I_fetchAddr(I_fetchAddr),
    .I_dataReq(I_dataReq), .I_dataWe(I_dataWe), .I_dataAddr(I_dataAddr),
    .I_dataWdata(I_dataWdata), .I_memRdata(I_memRdata),
    .O_memE(O_memE), .O_memWe(O_memWe), .O_memAddr(O_memAddr),
    .O_memWdata(O_memWdata), .O_fetchData(O_fetchData),
    .O_fetchValid(O_fetchValid), .O_dataRdata(O_dataRdata),
    .O_dataValid(O_dataValid), .O_stallFetch(O_stallFetch),
    .O_stallData(O_stallData)
  );

  always #5 I_clk = ~I_clk;

  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  // Memory driven by the DUT, and the bench's own expectation of its contents.
  logic [31:0] mem     [0:16383];
  logic [31:0] exp_mem [0:16383];
  always @(posedge I_clk) begin
    if (O_memE) begin
      I_memRdata <= mem[O_memAddr];
      for (int b = 0; b < 4; b++)
        if (O_memWe[b]) mem[O_memAddr][b*8 +: 8] <= O_memWdata[b*8 +: 8];
    end
  end

  typedef struct {
    logic [31:0] data;
    int          cyc;
    logic        wr;
  } rsp_t;

  rsp_t        qf[$];
  rsp_t        qd[$];
  logic [31:0] mon_f = '0;
  logic [31:0] mon_d = '0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // One cycle of stimulus. g: expected grant 0=none, 1=fetch, 2=data.
  task automatic drive(input logic rst, input logic fr, input logic [13:0] fa,
                       input logic dr, input logic [3:0] we, input logic [31:0] da,
                       input logic [31:0] wd, input int g, input string nm);
    logic [13:0] w;
    @(posedge I_clk);
    #1;
    I_rst = rst; I_fetchReq = fr; I_fetchAddr = fa;
    I_dataReq = dr; I_dataWe = we; I_dataAddr = da; I_dataWdata = wd;
    if (rst) begin
      qf.delete(); qd.delete(); mon_f = '0; mon_d = '0;
    end
    @(negedge I_clk);
    w = da[15:2];
    chk({nm, "_memE"}, 32'(O_memE), 32'(g != 0));
    chk({nm, "_stallF"}, 32'(O_stallFetch), 32'(fr && g != 1));
    chk({nm, "_stallD"}, 32'(O_stallData), 32'(dr && g != 2));
    chk({nm, "_memWe"}, 32'(O_memWe), (g == 2) ? 32'(we) : 32'h0);
    if (g == 1) begin
      chk({nm, "_addr"}, 32'(O_memAddr), 32'(fa));
      qf.push_back('{exp_mem[fa], cyc + 1, 1'b0});
    end else if (g == 2) begin
      chk({nm, "_addr"}, 32'(O_memAddr), 32'(w));
      if (we == 4'b0000) begin
        qd.push_back('{exp_mem[w], cyc + 1, 1'b0});
      end else begin
        chk({nm, "_wdata"}, O_memWdata, wd);
        for (int b = 0; b < 4; b++)
          if (we[b]) exp_mem[w][b*8 +: 8] = wd[b*8 +: 8];
        qd.push_back('{32'h0, cyc + 1, 1'b1});
      end
    end
  endtask

  // Response monitor.
  always @(negedge I_clk) begin
    rsp_t r;
    if (I_rst) begin
      chk("rst_fetchValid", 32'(O_fetchValid), 32'h0);
      chk("rst_dataValid", 32'(O_dataValid), 32'h0);
    end else begin
      if (O_fetchValid) begin
        if (qf.size() == 0) miss("fetch_unexpected_valid");
        else begin
          r = qf.pop_front();
          chk("fetch_rsp_cycle", 32'(cyc), 32'(r.cyc));
          chk("fetch_rsp_data", O_fetchData, r.data);
          mon_f = r.data;
        end
      end else begin
        chk("fetch_hold", O_fetchData, mon_f);
        if (qf.size() > 0 && qf[0].cyc <= cyc) begin
          miss("fetch_missing_valid");
          void'(qf.pop_front());
        end
      end
      if (O_dataValid) begin
        if (qd.size() == 0) miss("data_unexpected_valid");
        else begin
          r = qd.pop_front();
          chk("data_rsp_cycle", 32'(cyc), 32'(r.cyc));
          if (r.wr) chk("data_store_hold", O_dataRdata, mon_d);
          else begin
            chk("data_rsp_data", O_dataRdata, r.data);
            mon_d = r.data;
          end
        end
      end else begin
        chk("data_hold", O_dataRdata, mon_d);
        if (qd.size() > 0 && qd[0].cyc <= cyc) begin
          miss("data_missing_valid");
          void'(qd.pop_front());
        end
      end
    end
  end

  initial begin
    int g;
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = 32'hC0DE0000 | 32'(i);
      exp_mem[i] = 32'hC0DE0000 | 32'(i);
    end
    mem[16] = 32'h12345678; exp_mem[16] = 32'h12345678;
    mem[1]  = 32'h11223344; exp_mem[1]  = 32'h11223344;

    drive(1, 0, 0, 0, 0, 0, 0, 0, "reset0");
    drive(1, 0, 0, 0, 0, 0, 0, 0, "reset1");
    drive(0, 0, 0, 0, 0, 0, 0, 0, "idle");

    // Lone fetch, then hold.
    drive(0, 1, 14'h0010, 0, 0, 0, 0, 1, "fetch");
    drive(0, 0, 0, 0, 0, 0, 0, 0, "idle");
    drive(0, 0, 0, 0, 0, 0, 0, 0, "idle");

    // Collision: data wins, fetch goes next.
    drive(0, 1, 14'h0001, 1, 4'b0000, 32'h0000_0040, 0, 2, "collide");
    drive(0, 1, 14'h0001, 0, 0, 0, 0, 1, "collide_f");
    drive(0, 0, 0, 0, 0, 0, 0, 0, "idle");

    // Byte store to lane 2 of word 1, then read it back both ways.
    drive(0, 0, 0, 1, 4'b0100, 32'h0000_0006, 32'hABABABAB, 2, "store");
    drive(0, 0, 0, 1, 4'b0000, 32'h0000_0004, 0, 2, "load_back");
    drive(0, 1, 14'h0001, 0, 0, 0, 0, 1, "fetch_back");
    drive(0, 0, 0, 0, 0, 0, 0, 0, "idle");

    // Back-to-back F, D, F.
    drive(0, 1, 14'h0010, 0, 0, 0, 0, 1, "b2b_f0");
    drive(0, 0, 0, 1, 4'b0000, 32'h0000_0008, 0, 2, "b2b_d");
    drive(0, 1, 14'h0003, 0, 0, 0, 0, 1, "b2b_f1");
    drive(0, 0, 0, 0, 0, 0, 0, 0, "idle");

    // Both requesters held active.
    for (int i = 0; i < 7; i++) begin
`ifdef CEESPU_ARB_FAIRNESS_EN
      g = (i == 4) ? 1 : 2;
`else
      g = 2;
`endif
      drive(0, 1, 14'h0005, 1, 4'b0000, 32'h0000_0018, 0, g, "contend");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, "idle");

    // Reset lands in the response cycle of a fetch.
    drive(0, 1, 14'h0007, 0, 0, 0, 0, 1, "pre_rst_fetch");
    drive(1, 0, 0, 0, 0, 0, 0, 0, "mid_rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0, "post_rst");
    drive(0, 1, 14'h0008, 0, 0, 0, 0, 1, "post_rst_fetch");

    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, "drain");
    chk("fetch_queue_empty", 32'(qf.size()), 32'h0);
    chk("data_queue_empty", 32'(qd.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ceespu_mem_arbiter

// File: doc/ceespu_mem_arbiter.md
CEESPU_MEM_ARBITER -- requirements
Module: ceespu_mem_arbiter

Interface
REQ-001 SHALL have port I_clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port I_rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port I_fetchReq, input, 1: instruction fetch requests a word read.
REQ-004 SHALL have port I_fetchAddr, input, 14: fetch word address.
REQ-005 SHALL have port I_dataReq, input, 1: execute stage memory access request.
REQ-006 SHALL have port I_dataWe, input, 4: byte write enables; 4'b0000 means read.
REQ-007 SHALL have port I_dataAddr, input, 32: byte address; bits [15:2] select the word.
REQ-008 SHALL have port I_dataWdata, input, 32: store data, already lane-replicated.
REQ-009 SHALL have port I_memRdata, input, 32: shared synchronous memory read data, valid one cycle after the access.
REQ-010 SHALL have port O_memE, output, 1: memory enable.
REQ-011 SHALL have port O_memWe, output, 4: memory byte write enables.
REQ-012 SHALL have port O_memAddr, output, 14: memory word address.
REQ-013 SHALL have port O_memWdata, output, 32: memory write data.
REQ-014 SHALL have port O_fetchData, output, 32: fetch read data.
REQ-015 SHALL have port O_fetchValid, output, 1: fetch response strobe.
REQ-016 SHALL have port O_dataRdata, output, 32: load read data.
REQ-017 SHALL have port O_dataValid, output, 1: data access completion strobe.
REQ-018 SHALL have port O_stallFetch, output, 1: fetch request not granted this cycle.
REQ-019 SHALL have port O_stallData, output, 1: data request not granted this cycle.

Function
REQ-020 SHALL grant at most one requester per cycle; the grant is combinational from the requests and the fairness count.
REQ-021 SHALL give the data requester priority when both requesters are active, except as stated in REQ-031.
REQ-022 SHALL drive the granted request onto the memory port in the grant cycle T: O_memE=1, O_memAddr = fetch address or I_dataAddr[15:2], O_memWe = I_dataWe for a data grant and 0 for a fetch grant, O_memWdata = I_dataWdata.
REQ-023 SHALL drive O_memE=0 and O_memWe=0 when no requester is granted.
REQ-024 SHALL track the owner of the in-flight access in a registered FSM with states IDLE, FETCH and DATA; the next state is the owner granted in cycle T, or IDLE if none.
REQ-025 SHALL pulse O_fetchValid for exactly one cycle in T+1 when the state is FETCH; O_fetchData = I_memRdata in that cycle.
REQ-026 SHALL pulse O_dataValid in T+1 when the state is DATA, for both reads and writes; O_dataRdata = I_memRdata in that cycle for reads.
REQ-027 SHALL register each response word and hold O_fetchData and O_dataRdata at their last delivered value outside response cycles.
REQ-028 SHALL set O_stallFetch = I_fetchReq & ~fetchGrant and O_stallData = I_dataReq & ~dataGrant, both combinational.
REQ-029 SHALL support back-to-back grants: a new grant in T+1 overlaps the response for the T grant, and the FSM moves directly between FETCH and DATA without visiting IDLE.

Reset
REQ-030 SHALL, while I_rst=1, force the state to IDLE, clear the fairness count, zero both held data registers, and drive O_fetchValid=0 and O_dataValid=0 in the following cycle; a response in flight when reset asserts SHALL be discarded.

Configuration
REQ-031 SHALL implement a fairness guard when CEESPU_ARB_FAIRNESS_EN is defined:
  - a 3-bit count increments when data is granted while a fetch request is pending;
  - the count clears on any fetch grant, or whenever I_fetchReq=0;
  - when the count equals 4 and both requesters are active, fetch wins the grant.
REQ-032 SHALL apply strict data priority with no fairness count when CEESPU_ARB_FAIRNESS_EN is undefined.

Structure
REQ-033 SHALL take the FSM state encoding and the constant ARB_FAIR_LIMIT=4 from the shared package ceespu_pkg.
REQ-034 SHALL be a single module with no sub-modules.

Verification
REQ-035 SHALL verify a lone fetch: fetch at address 0x0010 with memory word 0x12345678 -> O_memAddr=0x0010, O_memWe=0 in T; O_fetchValid=1 and O_fetchData=0x12345678 in T+1; data held afterwards.
REQ-036 SHALL verify collision priority: I_fetchReq=I_dataReq=1 with a load at 0x00000040 -> O_memAddr=0x0010, data granted, O_stallFetch=1, O_stallData=0; fetch granted the next cycle.
REQ-037 SHALL verify a byte store: I_dataWe=4'b0100 with address 0x00000006 -> O_memWe=4'b0100, O_memAddr=1, O_dataValid=1 in T+1.
REQ-038 SHALL verify fairness with the macro defined: both requesters held active continuously -> grants D,D,D,D,F,D...; without the macro, fetch stalls for as long as data requests.
REQ-039 SHALL verify reset mid-access: I_rst asserted in T+1 of a fetch -> O_fetchValid=0 and O_fetchData=0 after reset, with the state IDLE.
REQ-040 SHALL verify back-to-back alternation F,D,F -> valid pulses in three consecutive cycles, each carrying the correct word.
